dmem_access_unit: RTL
=====================

DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the byte-address width of the req_addr and mem_addr ports.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL be fixed at 32 (four byte lanes); any other value is unsupported.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 req_valid  in  1  SHALL indicate a pipeline M-stage data access is presented.
REQ-006 req_we  in  1  SHALL select store (1) or load (0).
REQ-007 req_size  in  3  SHALL carry funct3: 0=B, 1=H, 2=W, 4=BU, 5=HU.
REQ-008 req_addr  in  ADDR_WIDTH  SHALL carry the byte address.
REQ-009 req_wdata  in  32  SHALL carry store data, right-justified.
REQ-010 stall  out  1  SHALL freeze the pipeline while high.
REQ-011 rdata  out  32  SHALL carry the extended load result; rdata_valid  out  1  SHALL mark its valid cycle.
REQ-012 misalign  out  1  SHALL flag a rejected misaligned access.
REQ-013 mem_req_valid out 1, mem_req_ready in 1, mem_we out 1, mem_addr out ADDR_WIDTH (word-aligned), mem_wdata out 32, mem_wstrb out 4 SHALL form the request channel.
REQ-014 mem_resp_valid in 1, mem_rdata in 32 SHALL form the load response channel.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, WAIT, DONE.
REQ-016 IDLE, req_valid=1: the request SHALL be captured and the FSM SHALL go to REQ; stall SHALL be 1 combinationally in that cycle.
REQ-017 REQ: mem_req_valid=1 with stable payload until mem_req_ready=1; on handshake, stores SHALL go to DONE and loads to WAIT.
REQ-018 WAIT: on mem_resp_valid=1, the extended data SHALL be registered and the FSM SHALL go to DONE.
REQ-019 stall SHALL be 1 in REQ and WAIT, and 0 in IDLE (no request) and in DONE.
REQ-020 DONE: rdata_valid SHALL be 1 for loads for exactly one cycle; req_valid SHALL be ignored; the next state SHALL be IDLE.
REQ-021 Minimum latency with ready and resp held high SHALL be: load 3 stalled cycles, store 2 stalled cycles.
REQ-022 Byte lanes: B/BU strb=0001<<addr[1:0]; H/HU strb=0011<<{addr[1],0}; W strb=1111. wdata SHALL be replicated into every lane.
REQ-023 Loads SHALL shift mem_rdata right by the lane offset, sign-extending for B/H and zero-extending for BU/HU.
REQ-024 Undefined size codes 3, 6, 7 SHALL behave as W.
REQ-025 mem_resp_valid SHALL be ignored outside WAIT; mem_req_ready SHALL be ignored outside REQ.
REQ-026 rdata SHALL hold its last value until the next load completes.

Reset
REQ-027 Reset low SHALL force, asynchronously, state=IDLE and set stall, mem_req_valid, rdata_valid and misalign to 0, rdata=0 and captured registers=0, including mid-transaction (an outstanding memory response is then dropped).

Configuration
REQ-028 With DMEM_MISALIGN_TRAP_EN defined, H with addr[0]=1 or W with addr[1:0]!=0 SHALL skip REQ/WAIT and go IDLE->DONE with misalign=1 for one cycle, no memory request, rdata_valid=0.
REQ-029 Without DMEM_MISALIGN_TRAP_EN, misalign SHALL be tied 0 and offset bits SHALL be masked per REQ-022 (H ignores addr[0], W ignores addr[1:0]).

Structure
REQ-030 Shared package riscv151_pkg SHALL hold the size-code constants and the FSM state encoding.
REQ-031 Lane steering and extension SHALL live in one combinational sub-module, dmem_align.

Verification
REQ-032 SB addr=0x1003, wdata=0x000000AB, ready=1 -> mem_addr=0x1000, wstrb=1000, wdata=0xABABABAB, stall high for 2 cycles.
REQ-033 LB addr=0x2002, mem_rdata=0x00F00000 -> rdata=0xFFFFFFF0; LBU at the same address -> rdata=0x000000F0; rdata_valid pulses 1 cycle.
REQ-034 LW with mem_req_ready low for 4 cycles, then resp 2 cycles later -> mem_req_valid and payload stable for 5 cycles, stall high for 8 cycles.
REQ-035 Reset asserted in WAIT, then a late mem_resp_valid -> state IDLE, stall 0, no rdata_valid.
REQ-036 With DMEM_MISALIGN_TRAP_EN, LH addr=0x3001 -> no mem_req_valid, misalign=1 for 1 cycle, stall 1 cycle.
REQ-037 Back-to-back SW then LW with req_valid held through DONE -> exactly two memory requests.

Source files
------------

// File: rtl/riscv151_pkg.sv
//------------------------------------------------------------------------------
// Module   : riscv151_pkg
// Brief    : Shared load/store size codes, helper decoders and the data-memory
//            access FSM state encoding.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package riscv151_pkg;

  localparam logic [2:0] c_size_b  = 3'd0;
  localparam logic [2:0] c_size_h  = 3'd1;
  localparam logic [2:0] c_size_w  = 3'd2;
  localparam logic [2:0] c_size_bu = 3'd4;
  localparam logic [2:0] c_size_hu = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } dmem_state_t;

  // Any code that is neither a byte nor a halfword access is treated as a word.
  function automatic logic size_is_byte(input logic [2:0] size);
    return (size == c_size_b) || (size == c_size_bu);
  endfunction

  function automatic logic size_is_half(input logic [2:0] size);
    return (size == c_size_h) || (size == c_size_hu);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_align.sv
//------------------------------------------------------------------------------
// Module   : dmem_align
// Brief    : Combinational byte-lane steering for stores and shift/extension
//            for loads. Sub-size offset bits are masked to the access size.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_align
  import riscv151_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic [1:0]  w_off;
  logic [31:0] w_shifted;
  logic        w_signed;

  always_comb begin
    w_off      = 2'b00;
    wstrb      = 4'b1111;
    lane_wdata = store_data;
    w_signed   = (size == c_size_b) || (size == c_size_h);
    if (size_is_byte(size)) begin
      w_off      = offset;
      wstrb      = 4'b0001 << offset;
      lane_wdata = {4{store_data[7:0]}};
    end else if (size_is_half(size)) begin
      w_off      = {offset[1], 1'b0};
      wstrb      = 4'b0011 << w_off;
      lane_wdata = {2{store_data[15:0]}};
    end
    w_shifted = mem_rdata >> {w_off, 3'b000};
    load_data = w_shifted;
    if (size_is_byte(size)) begin
      load_data = {{24{w_signed & w_shifted[7]}}, w_shifted[7:0]};
    end else if (size_is_half(size)) begin
      load_data = {{16{w_signed & w_shifted[15]}}, w_shifted[15:0]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_access_unit.sv
//------------------------------------------------------------------------------
// Module   : dmem_access_unit
// Brief    : M-stage data-memory access FSM with valid/ready request channel.
//            Optional misaligned-access trap enabled by DMEM_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_access_unit
  import riscv151_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  misalign,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  dmem_state_t           r_state;
  dmem_state_t           w_next;
  logic                  r_we;
  logic [2:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_misalign;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic                  w_misaligned_in;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_misaligned_in = (size_is_half(req_size) && req_addr[0]) ||
                           (!size_is_byte(req_size) && !size_is_half(req_size) &&
                            (req_addr[1:0] != 2'b00));
`else
  assign w_misaligned_in = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    stall         = 1'b0;
    mem_req_valid = 1'b0;
    rdata_valid   = 1'b0;
    misalign      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          stall  = 1'b1;
          w_next = w_misaligned_in ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_next = r_we ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (mem_resp_valid) w_next = ST_DONE;
      end
      ST_DONE: begin
        rdata_valid = !r_we && !r_misalign;
        misalign    = r_misalign;
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request payload is captured once in IDLE so it stays stable while REQ waits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we       <= 1'b0;
      r_size     <= 3'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_misalign <= 1'b0;
      r_rdata    <= '0;
    end else begin
      if (r_state == ST_IDLE && req_valid) begin
        r_we       <= req_we;
        r_size     <= req_size;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_misalign <= w_misaligned_in;
      end
      if (r_state == ST_WAIT && mem_resp_valid) begin
        r_rdata <= w_load_data;
      end
    end
  end

  dmem_align u_align (
    .size       (r_size),
    .offset     (r_addr[1:0]),
    .store_data (r_wdata),
    .mem_rdata  (mem_rdata),
    .wstrb      (mem_wstrb),
    .lane_wdata (mem_wdata),
    .load_data  (w_load_data)
  );

  assign mem_we   = r_we;
  assign mem_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign rdata    = r_rdata;

endmodule

`default_nettype wire
